vend_ctrl: RTL and testbench
============================

# vend_ctrl

Transaction controller for the vending machine coin path. It accumulates inserted coins as credit and validates a product selection against per-product prices. It then sequences the product dispenser over a req/ack handshake and pays out change or refunds through a pulse-driven change hopper. It sits between the coin acceptor, the selection keypad, the dispenser motor driver and the change hopper, replacing the fixed-price coin state machine with a configurable, multi-product sequencer.

## Interface
Parameters:
- PRICE0, 5, price of product 0 in 0.5-yuan units
- PRICE1, 4, product 1 price (0.5-yuan units)
- PRICE2, 6, product 2 price (0.5-yuan units)
- PRICE3, 3, product 3 price (0.5-yuan units)
- CREDIT_MAX, 20, credit saturation limit (0.5-yuan units, ≤31)
- TIMEOUT, 1000, idle cycles in CREDIT before automatic refund

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- coin  in  2  one-cycle coin event: 00 none, 01 = 0.5 yuan, 10 = 1.0 yuan, 11 ignored
- sel_valid  in  1  one-cycle selection strobe
- sel_id  in  2  product index, sampled with sel_valid
- cancel  in  1  one-cycle refund request
- disp_req  out  1  dispense request, held until disp_ack
- disp_id  out  2  product index, stable while disp_req is high
- disp_ack  in  1  dispenser done
- chg_rdy  in  1  hopper can accept a payout pulse
- chg_pulse  out  1  pay one 0.5-yuan coin
- coin_inhibit  out  1  1 = coin acceptor must reject coins
- credit  out  5  current credit (0.5-yuan units)
- busy  out  1  high in DISPENSE, CHANGE and REFUND

## Operation
- States: IDLE, CREDIT, DISPENSE, CHANGE, REFUND (one-hot).
- **IDLE**
  - credit = 0.
  - A valid coin adds its value and moves to CREDIT.
  - sel_valid and cancel are ignored.
- **CREDIT**
  - Coins add to credit. credit saturates at CREDIT_MAX; excess value is lost.
  - coin_inhibit = 1 when credit ≥ CREDIT_MAX−1.
  - sel_valid with credit ≥ price(sel_id): latch disp_id, subtract the price and go to DISPENSE.
  - sel_valid with insufficient credit: ignored; the state stays CREDIT and the timer is reset.
  - cancel goes to REFUND.
  - The timeout counter resets on any coin or sel_valid. On reaching TIMEOUT it goes to REFUND.
  - Priority for simultaneous events: cancel > sel_valid > coin. A coin arriving in the same cycle as an accepted sel_valid or cancel is not counted; coin_inhibit covers this case externally.
- **DISPENSE**
  - disp_req = 1 until disp_ack is sampled high.
  - Then go to CHANGE if credit > 0, else IDLE.
- **CHANGE / REFUND**
  - Each cycle with chg_rdy = 1 and credit > 0: chg_pulse = 1 and credit decrements by 1.
  - When credit reaches 0, go to IDLE.
  - CHANGE and REFUND differ only in their entry cause.
- coin_inhibit = 1 in every state except IDLE and CREDIT. Coins arriving while inhibited are ignored.
- Width rules: credit is 5-bit unsigned. Price comparisons are unsigned. Addition is computed in 6 bits before clamping.

## Timing
- Reset values: state IDLE, credit 0, disp_req 0, disp_id 0, chg_pulse 0, coin_inhibit 0, busy 0. The timeout counter is cleared.
- All outputs are registered.
- credit reflects a coin one cycle after the coin cycle.
- disp_req rises one cycle after an accepted sel_valid.
- disp_ack high in cycle t: disp_req is low at t+1.
- chg_pulse is registered. A pulse appears the cycle after chg_rdy && credit > 0 is sampled. Back-to-back pulses are allowed while chg_rdy stays high.
- Refunding a credit of N takes N pulses, then IDLE one cycle after the last pulse.
- Reset asserted mid-dispense or mid-payout aborts immediately to the reset values. Credit is lost by design.

## Structure
- Shared package vend_pkg: state encoding localparams, coin code constants (COIN_NONE, COIN_HALF, COIN_ONE), credit width (5).
- Sub-module vend_payout: CHANGE/REFUND pulse engine. Inputs: credit load, chg_rdy. Outputs: chg_pulse, done.
- Price lookup is inline combinational logic in vend_ctrl.

## Test plan
- **Exact payment:** coin 10, 10, 01 (credit 5); sel_valid, sel_id=0 → disp_req with disp_id=0; ack → IDLE, zero chg_pulse.
- **Overpay:** credit 8; select product 3 → dispense, then 5 chg_pulse with chg_rdy held high; final credit 0.
- **Insufficient credit:** credit 2; select product 2 → no disp_req, state stays CREDIT, credit stays 2.
- **Timeout:** credit 3, TIMEOUT=16 in the bench, no activity → REFUND after 16 cycles, 3 pulses.
- **Hopper stall and priority:**
  - Refund with chg_rdy toggling 1,0,1 → pulses only in the cycles after chg_rdy = 1.
  - cancel together with sel_valid in CREDIT → REFUND and no disp_req.
- **Saturation and reset:**
  - Coins beyond 20 → credit holds at 20; coin_inhibit is high at 19.
  - rst_n low during DISPENSE → all outputs at their reset values in the same cycle.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending machine coin-path controller:
// state encoding, coin codes, credit width and coin value decoding.
package vend_pkg;

  // Width of the credit register, counted in 0.5-yuan units.
  localparam int CREDIT_W = 5;

  // One-hot state codes.
  localparam logic [4:0] S_IDLE_OH     = 5'b00001;
  localparam logic [4:0] S_CREDIT_OH   = 5'b00010;
  localparam logic [4:0] S_DISPENSE_OH = 5'b00100;
  localparam logic [4:0] S_CHANGE_OH   = 5'b01000;
  localparam logic [4:0] S_REFUND_OH   = 5'b10000;

  typedef enum logic [4:0] {
    ST_IDLE     = S_IDLE_OH,
    ST_CREDIT   = S_CREDIT_OH,
    ST_DISPENSE = S_DISPENSE_OH,
    ST_CHANGE   = S_CHANGE_OH,
    ST_REFUND   = S_REFUND_OH
  } state_t;

  // Coin acceptor event codes; 2'b11 is treated as no coin.
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_HALF = 2'b01;
  localparam logic [1:0] COIN_ONE  = 2'b10;

  // Value of a coin event in 0.5-yuan units, one bit wider than credit
  // so that the sum can be clamped without wrapping.
  function automatic logic [CREDIT_W:0] coin_value(input logic [1:0] code);
    logic [CREDIT_W:0] val;
    case (code)
      COIN_HALF: val = (CREDIT_W+1)'(1);
      COIN_ONE:  val = (CREDIT_W+1)'(2);
      COIN_NONE: val = '0;
      default:   val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vend_payout.sv
// Change/refund pulse engine. While active, every cycle in which the
// hopper is ready and credit remains produces one registered payout
// pulse; 'pay' tells the controller to take one unit off its credit.
module vend_payout
  import vend_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                active,
  input  logic [CREDIT_W-1:0] credit,
  input  logic                chg_rdy,
  output logic                pay,
  output logic                done,
  output logic                chg_pulse
);

  assign pay  = active && chg_rdy && (credit != '0);
  assign done = active && (credit == '0);

  // Register the payout strobe so the hopper sees a clean one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_pulse <= 1'b0;
    end else begin
      chg_pulse <= pay;
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine transaction controller: accumulates coin credit,
// validates selections against per-product prices, runs the dispenser
// req/ack handshake and pays out change or refunds via vend_payout.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE0     = 5,
  parameter int unsigned PRICE1     = 4,
  parameter int unsigned PRICE2     = 6,
  parameter int unsigned PRICE3     = 3,
  parameter int unsigned CREDIT_MAX = 20,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          coin,
  input  logic                sel_valid,
  input  logic [1:0]          sel_id,
  input  logic                cancel,
  output logic                disp_req,
  output logic [1:0]          disp_id,
  input  logic                disp_ack,
  input  logic                chg_rdy,
  output logic                chg_pulse,
  output logic                coin_inhibit,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  // The idle timer counts 0 .. TIMEOUT-1; the refund fires on the cycle
  // the last value is seen with no activity.
  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  localparam logic [CREDIT_W:0]   MAX_WIDE   = (CREDIT_W+1)'(CREDIT_MAX);
  localparam logic [CREDIT_W-1:0] MAX_CREDIT = CREDIT_W'(CREDIT_MAX);
  localparam logic [CREDIT_W-1:0] INHIBIT_AT = CREDIT_W'(CREDIT_MAX - 1);

  localparam logic [CREDIT_W-1:0] P0 = CREDIT_W'(PRICE0);
  localparam logic [CREDIT_W-1:0] P1 = CREDIT_W'(PRICE1);
  localparam logic [CREDIT_W-1:0] P2 = CREDIT_W'(PRICE2);
  localparam logic [CREDIT_W-1:0] P3 = CREDIT_W'(PRICE3);

  state_t              state;
  state_t              state_next;
  logic [CREDIT_W-1:0] credit_next;
  logic [TIMER_W-1:0]  timer;
  logic [TIMER_W-1:0]  timer_next;
  logic [1:0]          disp_id_next;
  logic                busy_next;
  logic                inhibit_next;

  logic [CREDIT_W-1:0] price_sel;
  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W-1:0] coin_sat;
  logic                coin_seen;

  logic                payout_active;
  logic                pay;
  logic                pay_done;

  // Price of the product currently presented on the keypad.
  always_comb begin
    price_sel = P0;
    case (sel_id)
      2'd0:    price_sel = P0;
      2'd1:    price_sel = P1;
      2'd2:    price_sel = P2;
      2'd3:    price_sel = P3;
      default: price_sel = P0;
    endcase
  end

  // Credit plus incoming coin, summed one bit wide and clamped so excess value is dropped.
  always_comb begin
    coin_val  = coin_value(coin);
    coin_seen = (coin_val != '0);
    coin_sum  = {1'b0, credit} + coin_val;
    coin_sat  = (coin_sum > MAX_WIDE) ? MAX_CREDIT : coin_sum[CREDIT_W-1:0];
  end

  assign payout_active = (state == ST_CHANGE) || (state == ST_REFUND);

  vend_payout u_payout (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (payout_active),
    .credit    (credit),
    .chg_rdy   (chg_rdy),
    .pay       (pay),
    .done      (pay_done),
    .chg_pulse (chg_pulse)
  );

  // Next-state, credit and timer logic; cancel beats sel_valid beats coin.
  always_comb begin
    state_next   = state;
    credit_next  = credit;
    timer_next   = timer;
    disp_id_next = disp_id;

    case (state)
      ST_IDLE: begin
        timer_next = '0;
        if (coin_seen) begin
          credit_next = coin_sat;
          state_next  = ST_CREDIT;
        end
      end

      ST_CREDIT: begin
        if (cancel) begin
          timer_next = '0;
          state_next = ST_REFUND;
        end else if (sel_valid) begin
          timer_next = '0;
          if (credit >= price_sel) begin
            credit_next  = credit - price_sel;
            disp_id_next = sel_id;
            state_next   = ST_DISPENSE;
          end else if (coin_seen) begin
            credit_next = coin_sat;
          end
        end else if (coin_seen) begin
          timer_next  = '0;
          credit_next = coin_sat;
        end else if (timer == TIMER_LAST) begin
          timer_next = '0;
          state_next = ST_REFUND;
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      ST_DISPENSE: begin
        if (disp_ack) begin
          state_next = (credit != '0) ? ST_CHANGE : ST_IDLE;
        end
      end

      ST_CHANGE, ST_REFUND: begin
        if (pay) begin
          credit_next = credit - 1'b1;
        end
        if (pay_done) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next  = ST_IDLE;
        credit_next = '0;
        timer_next  = '0;
      end
    endcase
  end

  // Output values derived from where the machine is heading next cycle.
  always_comb begin
    busy_next    = (state_next == ST_DISPENSE) || (state_next == ST_CHANGE) ||
                   (state_next == ST_REFUND);
    inhibit_next = busy_next ||
                   ((state_next == ST_CREDIT) && (credit_next >= INHIBIT_AT));
  end

  // State, credit, timer and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      credit       <= '0;
      timer        <= '0;
      disp_id      <= 2'd0;
      disp_req     <= 1'b0;
      busy         <= 1'b0;
      coin_inhibit <= 1'b0;
    end else begin
      state        <= state_next;
      credit       <= credit_next;
      timer        <= timer_next;
      disp_id      <= disp_id_next;
      disp_req     <= (state_next == ST_DISPENSE);
      busy         <= busy_next;
      coin_inhibit <= inhibit_next;
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: a hand-computed vector table,
// randomized traffic against a transaction-level model, and directed
// sequences for timeout, saturation and asynchronous reset.
module tb_vend_ctrl;

  localparam int CMAX = 20;
  localparam int TOUT = 16;

  logic       clk;
  logic       rst_n;
  logic [1:0] coin;
  logic       sel_valid;
  logic [1:0] sel_id;
  logic       cancel;
  logic       disp_req;
  logic [1:0] disp_id;
  logic       disp_ack;
  logic       chg_rdy;
  logic       chg_pulse;
  logic       coin_inhibit;
  logic [4:0] credit;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  vend_ctrl #(
    .PRICE0     (5),
    .PRICE1     (4),
    .PRICE2     (6),
    .PRICE3     (3),
    .CREDIT_MAX (CMAX),
    .TIMEOUT    (TOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin         (coin),
    .sel_valid    (sel_valid),
    .sel_id       (sel_id),
    .cancel       (cancel),
    .disp_req     (disp_req),
    .disp_id      (disp_id),
    .disp_ack     (disp_ack),
    .chg_rdy      (chg_rdy),
    .chg_pulse    (chg_pulse),
    .coin_inhibit (coin_inhibit),
    .credit       (credit),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before the test finished");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    int coin;
    int sv;
    int sid;
    int cn;
    int ack;
    int rdy;
    int e_credit;
    int e_req;
    int e_id;
    int e_busy;
    int e_inh;
    int e_pulse;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int c, sv, sid, cn, ack, rdy,
                              input int ecr, ereq, eid, ebusy, einh, epul);
    vec_t v;
    v.coin = c; v.sv = sv; v.sid = sid; v.cn = cn; v.ack = ack; v.rdy = rdy;
    v.e_credit = ecr; v.e_req = ereq; v.e_id = eid;
    v.e_busy = ebusy; v.e_inh = einh; v.e_pulse = epul;
    return v;
  endfunction

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endfunction

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic applyStimulus(input int c, sv, sid, cn, ack, rdy);
    coin      = 2'(c);
    sel_valid = 1'(sv);
    sel_id    = 2'(sid);
    cancel    = 1'(cn);
    disp_ack  = 1'(ack);
    chg_rdy   = 1'(rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int e_credit, e_req, e_id,
                             e_busy, e_inh, e_pulse);
    chk({tag, ".credit"},       int'(credit),       e_credit);
    chk({tag, ".disp_req"},     int'(disp_req),     e_req);
    chk({tag, ".busy"},         int'(busy),         e_busy);
    chk({tag, ".coin_inhibit"}, int'(coin_inhibit), e_inh);
    chk({tag, ".chg_pulse"},    int'(chg_pulse),    e_pulse);
    if (e_req != 0) chk({tag, ".disp_id"}, int'(disp_id), e_id);
  endtask

  // Transaction-level reference: a customer session expressed as a mode,
  // a credit balance and a count of quiet cycles.
  localparam int M_IDLE = 0, M_CREDIT = 1, M_DISPENSE = 2, M_PAYOUT = 3;
  int m_mode, m_credit, m_quiet, m_pid, m_pulse;

  function automatic int price_of(input int id);
    case (id)
      0: return 5;
      1: return 4;
      2: return 6;
      default: return 3;
    endcase
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE; m_credit = 0; m_quiet = 0; m_pid = 0; m_pulse = 0;
  endfunction

  function automatic void model_step(input int c, sv, sid, cn, ack, rdy);
    int val;
    val = (c == 1) ? 1 : ((c == 2) ? 2 : 0);
    m_pulse = 0;
    case (m_mode)
      M_IDLE: begin
        if (val > 0) begin
          m_credit = (val > CMAX) ? CMAX : val;
          m_quiet  = 0;
          m_mode   = M_CREDIT;
        end
      end
      M_CREDIT: begin
        if (cn != 0) begin
          m_mode = M_PAYOUT;
        end else if (sv != 0 && m_credit >= price_of(sid)) begin
          m_credit = m_credit - price_of(sid);
          m_pid    = sid;
          m_mode   = M_DISPENSE;
        end else if (sv != 0 || val > 0) begin
          m_credit = (m_credit + val > CMAX) ? CMAX : m_credit + val;
          m_quiet  = 0;
        end else begin
          m_quiet++;
          if (m_quiet >= TOUT) m_mode = M_PAYOUT;
        end
      end
      M_DISPENSE: begin
        if (ack != 0) m_mode = (m_credit > 0) ? M_PAYOUT : M_IDLE;
      end
      default: begin
        if (m_credit == 0) m_mode = M_IDLE;
        else if (rdy != 0) begin
          m_credit--;
          m_pulse = 1;
        end
      end
    endcase
  endfunction

  task automatic doReset(input string tag);
    rst_n = 1'b0;
    coin = 2'd0; sel_valid = 1'b0; sel_id = 2'd0;
    cancel = 1'b0; disp_ack = 1'b0; chg_rdy = 1'b0;
    @(posedge clk);
    #1;
    checkOutput(tag, 0, 0, 0, 0, 0, 0);
    chk({tag, ".disp_id"}, int'(disp_id), 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int n, pulses, rc, rsv, rsid, rcn, rack, rrdy, quiet;

    rst_n = 1'b0;
    coin = 2'd0; sel_valid = 1'b0; sel_id = 2'd0;
    cancel = 1'b0; disp_ack = 1'b0; chg_rdy = 1'b0;
    #12;
    doReset("rst0");

    // Exact payment; coins while dispensing and the 11 code are ignored.
    vecs.push_back(mk(3,0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(2,0,0,0,0,0, 2,0,0,0,0,0));
    vecs.push_back(mk(2,0,0,0,0,0, 4,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 5,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 0,1,0,1,1,0));
    vecs.push_back(mk(2,0,0,0,0,0, 0,1,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,1,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0));
    // Overpay: credit 8, product 3, five change pulses.
    vecs.push_back(mk(2,0,0,0,0,0, 2,0,0,0,0,0));
    vecs.push_back(mk(2,0,0,0,0,0, 4,0,0,0,0,0));
    vecs.push_back(mk(2,0,0,0,0,0, 6,0,0,0,0,0));
    vecs.push_back(mk(2,0,0,0,0,0, 8,0,0,0,0,0));
    vecs.push_back(mk(0,1,3,0,0,0, 5,1,3,1,1,0));
    vecs.push_back(mk(0,0,0,0,1,1, 5,0,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,0,1, 4,0,0,1,1,1));
    vecs.push_back(mk(0,0,0,0,0,1, 3,0,0,1,1,1));
    vecs.push_back(mk(0,0,0,0,0,1, 2,0,0,1,1,1));
    vecs.push_back(mk(0,0,0,0,0,1, 1,0,0,1,1,1));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,1,1,1));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0));
    // Insufficient credit, then cancel with a stalling hopper (1,0,1).
    vecs.push_back(mk(2,0,0,0,0,0, 2,0,0,0,0,0));
    vecs.push_back(mk(0,1,2,0,0,0, 2,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0, 2,0,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,0,0,1,1,1));
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,1,1,1));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0));
    // Cancel beats an affordable selection and a simultaneous coin.
    vecs.push_back(mk(2,0,0,0,0,0, 2,0,0,0,0,0));
    vecs.push_back(mk(2,0,0,0,0,0, 4,0,0,0,0,0));
    vecs.push_back(mk(1,1,3,1,0,0, 4,0,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,0,1, 3,0,0,1,1,1));
    vecs.push_back(mk(0,0,0,0,0,1, 2,0,0,1,1,1));
    vecs.push_back(mk(0,0,0,0,0,1, 1,0,0,1,1,1));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,1,1,1));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].coin, vecs[i].sv, vecs[i].sid, vecs[i].cn,
                    vecs[i].ack, vecs[i].rdy);
      checkOutput($sformatf("tbl[%0d]", i), vecs[i].e_credit, vecs[i].e_req,
                  vecs[i].e_id, vecs[i].e_busy, vecs[i].e_inh, vecs[i].e_pulse);
    end

    // Randomized traffic with alternating busy and quiet stretches.
    doReset("rst1");
    for (int i = 0; i < 3000; i++) begin
      quiet = (((i / 48) % 3) == 2) ? 1 : 0;
      rc    = (quiet == 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      rsv   = (quiet == 0 && $urandom_range(0, 5) == 0) ? 1 : 0;
      rsid  = int'($urandom_range(0, 3));
      rcn   = (quiet == 0 && $urandom_range(0, 29) == 0) ? 1 : 0;
      rack  = ($urandom_range(0, 2) == 0) ? 1 : 0;
      rrdy  = ($urandom_range(0, 2) != 0) ? 1 : 0;
      applyStimulus(rc, rsv, rsid, rcn, rack, rrdy);
      model_step(rc, rsv, rsid, rcn, rack, rrdy);
      checkOutput($sformatf("rnd[%0d]", i), m_credit,
                  (m_mode == M_DISPENSE) ? 1 : 0, m_pid,
                  (m_mode >= M_DISPENSE) ? 1 : 0,
                  ((m_mode >= M_DISPENSE) || (m_mode == M_CREDIT && m_credit >= CMAX - 1)) ? 1 : 0,
                  m_pulse);
    end

    // Timeout: credit 3 left alone refunds after TOUT quiet cycles.
    doReset("rst2");
    applyStimulus(2, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    chk("timeout.credit", int'(credit), 3);
    n = 0;
    do begin
      applyStimulus(0, 0, 0, 0, 0, 1);
      n++;
    end while (busy != 1'b1 && n < 100);
    chk("timeout.cycles", n, TOUT);
    n = 0;
    pulses = 0;
    do begin
      applyStimulus(0, 0, 0, 0, 0, 1);
      n++;
      if (chg_pulse == 1'b1) pulses++;
    end while (busy == 1'b1 && n < 100);
    chk("timeout.pulses", pulses, 3);
    chk("timeout.drain_cycles", n, 4);
    chk("timeout.final_credit", int'(credit), 0);

    // Saturation at CMAX, inhibit from CMAX-1, then reset mid-dispense.
    doReset("rst3");
    for (int i = 0; i < 9; i++) applyStimulus(2, 0, 0, 0, 0, 0);
    checkOutput("sat18", 18, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("sat19", 19, 0, 0, 0, 1, 0);
    applyStimulus(2, 0, 0, 0, 0, 0);
    checkOutput("sat20", 20, 0, 0, 0, 1, 0);
    applyStimulus(2, 0, 0, 0, 0, 0);
    checkOutput("sat_hold", 20, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 2, 0, 0, 0);
    checkOutput("sat_buy", 14, 1, 2, 1, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst", 0, 0, 0, 0, 0, 0);
    chk("async_rst.disp_id", int'(disp_id), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("post_rst", 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
